// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: alignment check, lane steering of store data,
// single-outstanding valid/ready bus transaction, and raw load hand-off to the load filter.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    input  logic                  reqWrite,
    input  logic [ADDR_WIDTH-1:0] reqAddr,
    input  logic [31:0]           reqWdata,
    input  logic [2:0]            reqFunc3,
    output logic                  stall,
    output logic                  accessErr,
    output logic                  memReqValid,
    input  logic                  memReqReady,
    output logic                  memReqWrite,
    output logic [ADDR_WIDTH-1:0] memReqAddr,
    output logic [31:0]           memReqWdata,
    output logic [3:0]            memReqWstrb,
    input  logic                  memRespValid,
    input  logic [31:0]           memRespData,
    output logic                  ldValid,
    output logic [31:0]           ldMemData,
    output logic [1:0]            ldByteOffset,
    output logic [2:0]            ldFunc3
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t state_q, state_d;

    logic        misaligned;
    logic        accept;
    logic        capture;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;

    // Size is func3[1:0]; the reserved size 11 is treated as misaligned.
    always_comb begin
        misaligned = 1'b0;
        lane_wdata = reqWdata;
        lane_wstrb = 4'b0000;
        case (reqFunc3[1:0])
            2'b00: begin
                lane_wdata = {4{reqWdata[7:0]}};
                lane_wstrb = 4'b0001 << reqAddr[1:0];
            end
            2'b01: begin
                misaligned = reqAddr[0];
                lane_wdata = {2{reqWdata[15:0]}};
                lane_wstrb = 4'b0011 << {reqAddr[1], 1'b0};
            end
            2'b10: begin
                misaligned = (reqAddr[1:0] != 2'b00);
                lane_wstrb = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign accept  = (state_q == S_IDLE) && reqValid && !misaligned;
    assign capture = ((state_q == S_REQ) && memReqReady && memRespValid) ||
                     ((state_q == S_RESP) && memRespValid);

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        accessErr   = 1'b0;
        memReqValid = 1'b0;
        ldValid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (reqValid && misaligned) begin
                    accessErr = 1'b1;
                end else if (reqValid) begin
                    stall   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                stall       = 1'b1;
                memReqValid = 1'b1;
                if (memReqReady) begin
                    state_d = memRespValid ? S_DONE : S_RESP;
                end
            end
            S_RESP: begin
                stall = 1'b1;
                if (memRespValid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // reqValid here is the finishing instruction itself, not a new one.
                ldValid = !memReqWrite;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            memReqWrite  <= 1'b0;
            memReqAddr   <= '0;
            memReqWdata  <= '0;
            memReqWstrb  <= 4'b0000;
            ldMemData    <= '0;
            ldByteOffset <= 2'b00;
            ldFunc3      <= 3'b000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                memReqWrite  <= reqWrite;
                memReqAddr   <= {reqAddr[ADDR_WIDTH-1:2], 2'b00};
                memReqWdata  <= reqWrite ? lane_wdata : 32'h0;
                memReqWstrb  <= reqWrite ? lane_wstrb : 4'b0000;
                ldByteOffset <= reqAddr[1:0];
                ldFunc3      <= reqFunc3;
            end
            if (capture && !memReqWrite) begin
                ldMemData <= memRespData;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change just after the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqFunc3;
    logic        stall;
    logic        accessErr;
    logic        memReqValid;
    logic        memReqReady;
    logic        memReqWrite;
    logic [31:0] memReqAddr;
    logic [31:0] memReqWdata;
    logic [3:0]  memReqWstrb;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        ldValid;
    logic [31:0] ldMemData;
    logic [1:0]  ldByteOffset;
    logic [2:0]  ldFunc3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
        .reqWdata(reqWdata), .reqFunc3(reqFunc3),
        .stall(stall), .accessErr(accessErr),
        .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqWrite(memReqWrite), .memReqAddr(memReqAddr),
        .memReqWdata(memReqWdata), .memReqWstrb(memReqWstrb),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .ldValid(ldValid), .ldMemData(ldMemData),
        .ldByteOffset(ldByteOffset), .ldFunc3(ldFunc3)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
        reqFunc3 = 3'b000; memReqReady = 1'b0; memRespValid = 1'b0; memRespData = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk); #1;
        n_checks++; if (stall !== 1'b0) begin $display("FAIL reset_stall got %b exp 0", stall); n_fail++; end
        n_checks++; if (memReqValid !== 1'b0) begin $display("FAIL reset_reqvalid got %b exp 0", memReqValid); n_fail++; end
        n_checks++; if (memReqWstrb !== 4'b0000) begin $display("FAIL reset_wstrb got %b exp 0000", memReqWstrb); n_fail++; end
        n_checks++; if (ldMemData !== 32'h0) begin $display("FAIL reset_lddata got %h exp 0", ldMemData); n_fail++; end
        n_checks++; if ({ldValid, ldByteOffset, ldFunc3, accessErr} !== 7'b0) begin $display("FAIL reset_misc got %b exp 0", {ldValid, ldByteOffset, ldFunc3, accessErr}); n_fail++; end
        rst = 1'b0;
        next_cycle(); #1;
    endtask

    task automatic test_load_word();
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h1000; reqFunc3 = 3'b010;
        memReqReady = 1'b1; memRespValid = 1'b1; memRespData = 32'hDEADBEEF; #1;
        n_checks++; if (stall !== 1'b1) begin $display("FAIL lw_accept_stall got %b exp 1", stall); n_fail++; end
        n_checks++; if (memReqValid !== 1'b0) begin $display("FAIL lw_accept_reqvalid got %b exp 0", memReqValid); n_fail++; end
        next_cycle(); reqValid = 1'b0; #1;
        n_checks++; if (memReqValid !== 1'b1) begin $display("FAIL lw_req_valid got %b exp 1", memReqValid); n_fail++; end
        n_checks++; if (memReqAddr !== 32'h1000) begin $display("FAIL lw_req_addr got %h exp 1000", memReqAddr); n_fail++; end
        n_checks++; if (memReqWstrb !== 4'b0000) begin $display("FAIL lw_req_wstrb got %b exp 0000", memReqWstrb); n_fail++; end
        n_checks++; if ({memReqWrite, stall} !== 2'b01) begin $display("FAIL lw_req_write_stall got %b exp 01", {memReqWrite, stall}); n_fail++; end
        next_cycle(); memReqReady = 1'b0; memRespValid = 1'b0; #1;
        n_checks++; if ({stall, ldValid} !== 2'b01) begin $display("FAIL lw_done_stall_ldvalid got %b exp 01", {stall, ldValid}); n_fail++; end
        n_checks++; if (ldMemData !== 32'hDEADBEEF) begin $display("FAIL lw_done_data got %h exp deadbeef", ldMemData); n_fail++; end
        n_checks++; if (ldByteOffset !== 2'b00) begin $display("FAIL lw_done_offset got %b exp 00", ldByteOffset); n_fail++; end
        next_cycle(); #1;
        n_checks++; if ({stall, ldValid} !== 2'b00) begin $display("FAIL lw_after_idle got %b exp 00", {stall, ldValid}); n_fail++; end
    endtask

    task automatic test_store_byte();
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h2003; reqWdata = 32'h000000A5; reqFunc3 = 3'b000;
        memReqReady = 1'b1; memRespValid = 1'b1; memRespData = 32'h55555555; #1;
        n_checks++; if (stall !== 1'b1) begin $display("FAIL sb_accept_stall got %b exp 1", stall); n_fail++; end
        next_cycle(); reqValid = 1'b0; #1;
        n_checks++; if (memReqAddr !== 32'h2000) begin $display("FAIL sb_addr got %h exp 2000", memReqAddr); n_fail++; end
        n_checks++; if (memReqWdata !== 32'hA5A5A5A5) begin $display("FAIL sb_wdata got %h exp a5a5a5a5", memReqWdata); n_fail++; end
        n_checks++; if (memReqWstrb !== 4'b1000) begin $display("FAIL sb_wstrb got %b exp 1000", memReqWstrb); n_fail++; end
        n_checks++; if ({memReqValid, memReqWrite} !== 2'b11) begin $display("FAIL sb_valid_write got %b exp 11", {memReqValid, memReqWrite}); n_fail++; end
        next_cycle(); memReqReady = 1'b0; memRespValid = 1'b0; #1;
        n_checks++; if ({stall, ldValid} !== 2'b00) begin $display("FAIL sb_done_stall_ldvalid got %b exp 00", {stall, ldValid}); n_fail++; end
        n_checks++; if (ldMemData !== 32'hDEADBEEF) begin $display("FAIL sb_lddata_kept got %h exp deadbeef", ldMemData); n_fail++; end
        n_checks++; if (ldByteOffset !== 2'b11) begin $display("FAIL sb_offset got %b exp 11", ldByteOffset); n_fail++; end
        next_cycle(); #1;
    endtask

    task automatic test_store_half_backpressure();
        int stall_cycles;
        stall_cycles = 0;
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h3002; reqWdata = 32'h00001234; reqFunc3 = 3'b001;
        memReqReady = 1'b0; memRespValid = 1'b0; #1;
        if (stall === 1'b1) stall_cycles++;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); reqValid = 1'b0; #1;
            if (stall === 1'b1) stall_cycles++;
            n_checks++; if (memReqValid !== 1'b1) begin $display("FAIL sh_bp_valid[%0d] got %b exp 1", i, memReqValid); n_fail++; end
            n_checks++; if (memReqWdata !== 32'h12341234) begin $display("FAIL sh_bp_wdata[%0d] got %h exp 12341234", i, memReqWdata); n_fail++; end
            n_checks++; if (memReqWstrb !== 4'b1100) begin $display("FAIL sh_bp_wstrb[%0d] got %b exp 1100", i, memReqWstrb); n_fail++; end
        end
        next_cycle(); memReqReady = 1'b1; memRespValid = 1'b1; #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if ({memReqValid, memReqAddr} !== {1'b1, 32'h3000}) begin $display("FAIL sh_hs_valid_addr got %b/%h exp 1/3000", memReqValid, memReqAddr); n_fail++; end
        next_cycle(); memReqReady = 1'b0; memRespValid = 1'b0; #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++; if (ldValid !== 1'b0) begin $display("FAIL sh_done_ldvalid got %b exp 0", ldValid); n_fail++; end
        n_checks++; if (stall_cycles !== 5) begin $display("FAIL sh_stall_cycles got %0d exp 5", stall_cycles); n_fail++; end
        next_cycle(); #1;
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3];
        logic [2:0]  f3s   [3];
        addrs[0] = 32'h4001; f3s[0] = 3'b010;
        addrs[1] = 32'h4003; f3s[1] = 3'b001;
        addrs[2] = 32'h4000; f3s[2] = 3'b011;
        for (int i = 0; i < 3; i++) begin
            reqValid = 1'b1; reqWrite = 1'b0; reqAddr = addrs[i]; reqFunc3 = f3s[i];
            memReqReady = 1'b1; #1;
            n_checks++; if ({accessErr, stall, memReqValid} !== 3'b100) begin $display("FAIL mis_err[%0d] got %b exp 100", i, {accessErr, stall, memReqValid}); n_fail++; end
            next_cycle(); reqValid = 1'b0; #1;
            n_checks++; if ({accessErr, stall, memReqValid} !== 3'b000) begin $display("FAIL mis_after[%0d] got %b exp 000", i, {accessErr, stall, memReqValid}); n_fail++; end
            next_cycle(); #1;
        end
        memReqReady = 1'b0;
    endtask

    task automatic test_load_unsigned_half();
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h5002; reqFunc3 = 3'b101;
        memReqReady = 1'b1; memRespValid = 1'b1; memRespData = 32'h8001FFFF; #1;
        next_cycle(); reqValid = 1'b0; #1;
        n_checks++; if ({memReqAddr, memReqWstrb} !== {32'h5000, 4'b0000}) begin $display("FAIL lhu_req got %h/%b exp 5000/0000", memReqAddr, memReqWstrb); n_fail++; end
        next_cycle(); memReqReady = 1'b0; memRespValid = 1'b0; #1;
        n_checks++; if (ldValid !== 1'b1) begin $display("FAIL lhu_ldvalid got %b exp 1", ldValid); n_fail++; end
        n_checks++; if (ldMemData !== 32'h8001FFFF) begin $display("FAIL lhu_data got %h exp 8001ffff", ldMemData); n_fail++; end
        n_checks++; if ({ldByteOffset, ldFunc3} !== {2'b10, 3'b101}) begin $display("FAIL lhu_off_f3 got %b/%b exp 10/101", ldByteOffset, ldFunc3); n_fail++; end
        next_cycle(); #1;
    endtask

    task automatic test_back_to_back();
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h7004; reqFunc3 = 3'b010;
        memReqReady = 1'b1; memRespValid = 1'b1; memRespData = 32'h11223344; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        n_checks++; if ({stall, ldValid, accessErr} !== 3'b010) begin $display("FAIL b2b_done got %b exp 010", {stall, ldValid, accessErr}); n_fail++; end
        n_checks++; if (ldMemData !== 32'h11223344) begin $display("FAIL b2b_data got %h exp 11223344", ldMemData); n_fail++; end
        next_cycle(); #1;
        n_checks++; if ({stall, memReqValid, ldValid} !== 3'b100) begin $display("FAIL b2b_reaccept got %b exp 100", {stall, memReqValid, ldValid}); n_fail++; end
        next_cycle(); reqValid = 1'b0; memRespData = 32'h55667788; #1;
        n_checks++; if (memReqValid !== 1'b1) begin $display("FAIL b2b_req2 got %b exp 1", memReqValid); n_fail++; end
        next_cycle(); memReqReady = 1'b0; memRespValid = 1'b0; #1;
        n_checks++; if ({ldValid, ldMemData} !== {1'b1, 32'h55667788}) begin $display("FAIL b2b_done2 got %b/%h exp 1/55667788", ldValid, ldMemData); n_fail++; end
        next_cycle(); #1;
    endtask

    task automatic test_reset_in_resp();
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'h6004; reqFunc3 = 3'b010;
        memReqReady = 1'b1; memRespValid = 1'b0; #1;
        next_cycle(); reqValid = 1'b0; #1;
        n_checks++; if (memReqValid !== 1'b1) begin $display("FAIL rr_req got %b exp 1", memReqValid); n_fail++; end
        next_cycle(); memReqReady = 1'b0; #1;
        n_checks++; if ({memReqValid, stall} !== 2'b01) begin $display("FAIL rr_resp_wait got %b exp 01", {memReqValid, stall}); n_fail++; end
        next_cycle(); rst = 1'b1; #1;
        n_checks++; if ({stall, memReqValid, ldValid} !== 3'b000) begin $display("FAIL rr_reset_ctrl got %b exp 000", {stall, memReqValid, ldValid}); n_fail++; end
        n_checks++; if ({memReqAddr, ldByteOffset, ldFunc3, ldMemData} !== 69'b0) begin $display("FAIL rr_reset_data got %h/%b/%b/%h exp 0", memReqAddr, ldByteOffset, ldFunc3, ldMemData); n_fail++; end
        next_cycle(); rst = 1'b0; memRespValid = 1'b1; memRespData = 32'hCAFEF00D; #1;
        n_checks++; if ({stall, ldValid} !== 2'b00) begin $display("FAIL rr_late_resp got %b exp 00", {stall, ldValid}); n_fail++; end
        next_cycle(); #1;
        n_checks++; if ({ldValid, ldMemData} !== {1'b0, 32'h0}) begin $display("FAIL rr_late_resp2 got %b/%h exp 0/0", ldValid, ldMemData); n_fail++; end
        memRespValid = 1'b0;
        next_cycle(); #1;
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_store_half_backpressure();
        test_misaligned();
        test_load_unsigned_half();
        test_back_to_back();
        test_reset_in_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit for the pipelined RISC-V core. It sits between the EX/MEM pipeline register and the load filter. It checks alignment, builds the word-aligned bus request with shifted store data and byte strobes, and runs a valid/ready handshake to the data memory or bus bridge. While it waits it stalls the pipeline. On completion it hands the raw memory word, byte offset and func3 to the load filter for sign/zero extension.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of request and bus addresses

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- reqValid  in  1  MEM stage holds a load or store
- reqWrite  in  1  1 = store, 0 = load
- reqAddr  in  ADDR_WIDTH  effective byte address
- reqWdata  in  32  unshifted rs2 value
- reqFunc3  in  3  RISC-V load/store func3
- stall  out  1  pipeline must hold the current MEM-stage instruction
- accessErr  out  1  one-cycle pulse: misaligned or reserved-size access, no bus activity
- memReqValid  out  1  bus request valid
- memReqReady  in  1  bus accepts request
- memReqWrite  out  1  request is a write
- memReqAddr  out  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 0)
- memReqWdata  out  32  lane-replicated store data
- memReqWstrb  out  4  active-high byte strobes, 0000 for loads
- memRespValid  in  1  read data valid / write acknowledged
- memRespData  in  32  read word
- ldValid  out  1  one-cycle pulse: load result ready for the load filter
- ldMemData  out  32  registered memory word
- ldByteOffset  out  2  latched addr[1:0]
- ldFunc3  out  3  latched func3

## Operation
- Access size is func3[1:0]: 00 byte, 01 half, 10 word, 11 reserved. func3[2] marks an unsigned load and is passed through unchanged.
- Misaligned access: half with addr[0]=1, word with addr[1:0]≠00, or size 11.
- Store lanes:
  - Byte: wdata = {4{rs2[7:0]}}, wstrb = 0001 << off.
  - Half: wdata = {2{rs2[15:0]}}, wstrb = 0011 << (off[1]*2).
  - Word: wdata = rs2, wstrb = 1111.
- FSM has four states.
- IDLE
  - If reqValid is high and the access is misaligned: pulse accessErr for one cycle, stay in IDLE, stall=0.
  - If reqValid is high and the access is aligned: latch write, address, lane data, strobes, offset and func3; stall=1; go to REQ.
- REQ
  - memReqValid=1. All memReq* fields stay stable until memReqReady.
  - On handshake, go to RESP. If memRespValid is also high in the handshake cycle, capture the response and go straight to DONE.
- RESP
  - memReqValid=0.
  - Wait for memRespValid. For a load, register memRespData into ldMemData. Then go to DONE.
- DONE
  - stall=0. ldValid=1 for loads only.
  - reqValid is ignored, since it is the same instruction advancing. Go to IDLE.
- stall is 1 in REQ and RESP, and in IDLE when reqValid is high with an aligned access; otherwise 0.
- memRespValid outside REQ/RESP is ignored. Only one transaction is outstanding at any time.
- Stores leave ldMemData unchanged; ldByteOffset and ldFunc3 are updated on every accepted request.

## Timing
- Reset (asynchronous, immediate): state IDLE; every output 0, including stall, memReqValid, memReqWstrb, ldMemData, ldByteOffset and ldFunc3.
- Reset asserted mid-transaction drops memReqValid immediately and abandons the transaction. A late memRespValid after reset is ignored.
- Zero-wait memory (ready and response in the same cycle):
  - Cycle 0: IDLE accept, stall=1.
  - Cycle 1: REQ handshake plus response, stall=1.
  - Cycle 2: DONE, stall=0, ldValid=1.
  - Result: 2 stall cycles per access.
- Each cycle of memReqReady=0 adds one REQ cycle. Each cycle of response delay adds one RESP cycle.
- ldMemData, ldByteOffset and ldFunc3 are valid in the DONE cycle and hold until the next accepted request.
- accessErr is asserted in the same cycle reqValid is sampled; the error path does not stall.

## Test plan
- Zero-wait load word: reqAddr=0x1000, func3=010, memRespData=0xDEADBEEF → memReqAddr=0x1000, wstrb=0000; stall high 2 cycles; DONE cycle has ldValid=1, ldMemData=0xDEADBEEF, ldByteOffset=00.
- Store byte: addr=0x2003, rs2=0x000000A5, func3=000 → memReqAddr=0x2000, wdata=0xA5A5A5A5, wstrb=1000, memReqWrite=1; ldValid stays 0.
- Store half with backpressure: addr=0x3002, rs2=0x1234, memReqReady low 3 cycles → wdata=0x12341234 and wstrb=1100 held stable; stall high 5 cycles.
- Misaligned: load word at 0x4001, then half at 0x4003 → accessErr pulses each time; memReqValid never asserts; stall=0.
- Delayed response with reset: load accepted, response 4 cycles late, rst pulsed in RESP → outputs 0 immediately, FSM in IDLE, late memRespValid causes no ldValid.
- Load unsigned half: addr=0x5002, func3=101, memRespData=0x8001FFFF → ldMemData=0x8001FFFF, ldByteOffset=10, ldFunc3=101.
